// File: rtl/metro_card_reader.sv
// Fare-card tap deserializer and turnstile code-check initiator.
// Define READER_TAP_COUNT_EN to add the 16-bit tap_count grant counter.
module metro_card_reader #(
  parameter int BIT_TIMEOUT  = 8,
  parameter int RESP_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rset,
  input  logic       card_bit_valid,
  input  logic       card_bit,
  input  logic       door_open,
  output logic       validate_code,
  output logic [3:0] access_code,
  output logic       busy,
  output logic       granted,
  output logic       reject,
  output logic       frame_err,
  output logic [2:0] state_out
`ifdef READER_TAP_COUNT_EN
  ,
  output logic [15:0] tap_count
`endif
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT     = 3'd1,
    ISSUE     = 3'd2,
    WAIT_DOOR = 3'd3,
    DOOR_OPEN = 3'd4,
    ERR       = 3'd5
  } state_t;

  localparam logic [3:0] BIT_TO  = 4'(BIT_TIMEOUT);
  localparam logic [3:0] RESP_TO = 4'(RESP_TIMEOUT);

  state_t     state, state_n;
  logic [4:0] shreg, shreg_n;
  logic [2:0] cnt, cnt_n;
  logic [3:0] timer, timer_n, timer_inc;
  logic [3:0] code_n;
  logic       granted_n, reject_n, ferr_n;

  assign timer_inc = (timer == 4'hF) ? timer : timer + 4'd1;

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    cnt_n     = cnt;
    timer_n   = timer;
    code_n    = access_code;
    granted_n = 1'b0;
    reject_n  = 1'b0;
    ferr_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (card_bit_valid && card_bit) begin
          state_n = SHIFT;
          shreg_n = '0;
          cnt_n   = '0;
          timer_n = '0;
        end
      end
      SHIFT: begin
        if (card_bit_valid) begin
          shreg_n = {shreg[3:0], card_bit};
          cnt_n   = cnt + 3'd1;
          timer_n = '0;
          // fifth bit is parity; shreg[3:0] already holds the code
          if (cnt == 3'd4) begin
            if ((^shreg[3:0]) == card_bit) begin
              state_n = ISSUE;
              code_n  = shreg[3:0];
            end else begin
              state_n = ERR;
            end
          end
        end else begin
          timer_n = timer_inc;
          if (timer_inc >= BIT_TO) state_n = ERR;
        end
      end
      ISSUE: begin
        state_n = WAIT_DOOR;
        timer_n = '0;
      end
      WAIT_DOOR: begin
        if (door_open) begin
          state_n = DOOR_OPEN;
        end else begin
          timer_n = timer_inc;
          if (timer_inc >= RESP_TO) begin
            state_n  = IDLE;
            reject_n = 1'b1;
          end
        end
      end
      DOOR_OPEN: begin
        if (!door_open) begin
          state_n   = IDLE;
          granted_n = 1'b1;
        end
      end
      ERR: begin
        state_n = IDLE;
        ferr_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rset) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      timer       <= '0;
      access_code <= '0;
      granted     <= 1'b0;
      reject      <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      cnt         <= cnt_n;
      timer       <= timer_n;
      access_code <= code_n;
      granted     <= granted_n;
      reject      <= reject_n;
      frame_err   <= ferr_n;
    end
  end

`ifdef READER_TAP_COUNT_EN
  always_ff @(posedge clk) begin
    if (rset) tap_count <= '0;
    else if (granted_n) tap_count <= tap_count + 16'd1;
  end
`endif

  assign validate_code = (state == ISSUE);
  assign busy          = (state != IDLE);
  assign state_out     = state;

endmodule

// File: tb/tb_metro_card_reader.sv
// Scoreboard bench for metro_card_reader: random taps vs. a frame-level
// reference model; a negedge monitor pops expected events as outputs fire.
module tb_metro_card_reader;
  localparam int BT = 8;
  localparam int RT = 4;

  logic       clk = 1'b0;
  logic       rset;
  logic       card_bit_valid;
  logic       card_bit;
  logic       door_open;
  logic       validate_code;
  logic [3:0] access_code;
  logic       busy;
  logic       granted;
  logic       reject;
  logic       frame_err;
  logic [2:0] state_out;
`ifdef READER_TAP_COUNT_EN
  logic [15:0] tap_count;
`endif

  metro_card_reader #(.BIT_TIMEOUT(BT), .RESP_TIMEOUT(RT)) dut (
    .clk            (clk),
    .rset           (rset),
    .card_bit_valid (card_bit_valid),
    .card_bit       (card_bit),
    .door_open      (door_open),
    .validate_code  (validate_code),
    .access_code    (access_code),
    .busy           (busy),
    .granted        (granted),
    .reject         (reject),
    .frame_err      (frame_err),
    .state_out      (state_out)
`ifdef READER_TAP_COUNT_EN
    ,
    .tap_count      (tap_count)
`endif
  );

  always #5 clk = ~clk;

  typedef enum int {E_VAL, E_GRANT, E_REJ, E_FERR} kind_t;
  typedef struct {
    kind_t      kind;
    logic [3:0] code;
  } exp_t;

  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         vcyc = 0;
  int         grants = 0;
  logic [3:0] last_code = 4'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic observe(kind_t k);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)",
               int'(k), cyc);
    end else begin
      e = q.pop_front();
      check("event_kind", int'(k), int'(e.kind));
      check("event_code", int'(access_code), int'(e.code));
      if (k == E_REJ) check("reject_latency", cyc - vcyc, RT + 1);
    end
  endtask

  always @(negedge clk) begin
    if (int'(granted) + int'(reject) + int'(frame_err) > 1)
      check("pulse_exclusive", 0, 1);
    if (validate_code) begin
      vcyc = cyc;
      observe(E_VAL);
    end
    if (granted) begin
      grants++;
      observe(E_GRANT);
    end
    if (reject) observe(E_REJ);
    if (frame_err) observe(E_FERR);
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(logic b);
    card_bit_valid = 1'b1;
    card_bit       = b;
    idle(1);
    card_bit_valid = 1'b0;
    card_bit       = 1'($urandom);
  endtask

  task automatic send_bits(logic [5:0] bits, int n, bit gaps);
    for (int i = 0; i < n; i++) begin
      send_bit(bits[5 - i]);
      if (gaps && i < n - 1) idle($urandom_range(0, BT - 1));
    end
  endtask

  // companion turnstile: door rises 2 cycles after the strobe for codes 4..11
  task automatic good_frame(logic [3:0] code, int hold, bit gaps);
    logic [5:0] f;
    bit         opens;
    f     = {1'b1, code, ^code};
    opens = (code >= 4'd4) && (code <= 4'd11);
    q.push_back('{E_VAL, code});
    q.push_back('{opens ? E_GRANT : E_REJ, code});
    last_code = code;
    send_bits(f, 6, gaps);
    idle(1);
    if (opens) begin
      door_open = 1'b1;
      for (int i = 0; i < hold; i++) begin
        card_bit_valid = 1'($urandom);
        card_bit       = 1'($urandom);
        idle(1);
      end
      card_bit_valid = 1'b0;
      door_open      = 1'b0;
      idle(3);
    end else begin
      for (int i = 0; i < RT; i++) begin
        card_bit_valid = 1'($urandom);
        card_bit       = 1'($urandom);
        idle(1);
      end
      card_bit_valid = 1'b0;
      idle(4);
    end
  endtask

  task automatic bad_parity(logic [3:0] code);
    q.push_back('{E_FERR, last_code});
    send_bits({1'b1, code, ~^code}, 6, 1'b0);
    idle(4);
  endtask

  task automatic truncated(int k);
    logic [5:0] f;
    f = {1'b1, 5'($urandom)};
    q.push_back('{E_FERR, last_code});
    send_bits(f, k + 1, 1'b1);
    idle(BT + 3);
  endtask

  task automatic stale_inputs();
    door_open = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b0);
      check("idle_busy", int'(busy), 0);
    end
    door_open = 1'b0;
    idle(1);
  endtask

  task automatic reset_mid_frame();
    send_bits(6'b110000, 3, 1'b0);
    rset = 1'b1;
    idle(1);
    rset = 1'b0;
    check("rst_state", int'(state_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_code", int'(access_code), 0);
    last_code = 4'd0;
    idle(BT + 3);
  endtask

  initial begin
    int kind;
    int guard;
    rset           = 1'b1;
    card_bit_valid = 1'b0;
    card_bit       = 1'b0;
    door_open      = 1'b0;
    idle(3);
    check("reset_state", int'(state_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_code", int'(access_code), 0);
    check("reset_pulses",
          int'({validate_code, granted, reject, frame_err}), 0);
    rset = 1'b0;
    idle(2);

    good_frame(4'd6, 16, 1'b0);
    good_frame(4'd2, 0, 1'b0);
    bad_parity(4'd6);
    truncated(2);
    good_frame(4'd9, 3, 1'b0);
    stale_inputs();
    reset_mid_frame();
    good_frame(4'd11, 1, 1'b1);

    for (int t = 0; t < 150; t++) begin
      kind = $urandom_range(0, 9);
      if (kind < 5)
        good_frame(4'($urandom), $urandom_range(1, 16), 1'b1);
      else if (kind < 7)
        bad_parity(4'($urandom));
      else if (kind < 8)
        truncated($urandom_range(0, 4));
      else if (kind < 9)
        stale_inputs();
      else
        reset_mid_frame();
    end

    guard = 0;
    while (q.size() != 0 && guard < 100) begin
      idle(1);
      guard++;
    end
    check("queue_drained", q.size(), 0);
`ifdef READER_TAP_COUNT_EN
    check("tap_count", int'(tap_count), grants % 65536);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
